// File: rtl/maxpool_controller.sv
// Sequencer for a 2x2 max-pooling pass over a MAP_W x MAP_H feature map:
// fetches each window, hands it to an external pooling unit, writes the result.
module maxpool_controller #(
    parameter int data_size = 16,
    parameter int MAP_W     = 4,
    parameter int MAP_H     = 4,
    parameter int ADDR_W    = 4,
    parameter int OADDR_W   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [data_size-1:0]        rd_data,
    output logic [data_size-1:0]        pool_in1,
    output logic [data_size-1:0]        pool_in2,
    output logic [data_size-1:0]        pool_in3,
    output logic [data_size-1:0]        pool_in4,
    output logic                        pool_enable,
    input  logic signed [data_size-1:0] pool_result,
    input  logic                        pool_done,
    output logic                        wr_en,
    output logic [OADDR_W-1:0]          wr_addr,
    output logic [data_size-1:0]        wr_data
);

    // One spare bit so row+2 / col+2 compare against MAP_H / MAP_W without overflow.
    localparam int CW = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CAP   = 3'd2,
        POOL  = 3'd3,
        WAIT  = 3'd4,
        WRITE = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t               state_r, state_s;
    logic [1:0]           k_r, k_s;
    logic [CW-1:0]        row_r, row_s, col_r, col_s;
    logic                 last_s;
    logic [data_size-1:0] slot_r [4];
    logic [data_size-1:0] result_r;

    function automatic logic [ADDR_W-1:0] rd_index(input logic [CW-1:0] r,
                                                   input logic [CW-1:0] c,
                                                   input logic [1:0]    kk);
        logic [CW-1:0] a;
        a = r * CW'(MAP_W) + c;
        a = a + (kk[0] ? CW'(1) : CW'(0));
        a = a + (kk[1] ? CW'(MAP_W) : CW'(0));
        return a[ADDR_W-1:0];
    endfunction

    function automatic logic [OADDR_W-1:0] wr_index(input logic [CW-1:0] r,
                                                    input logic [CW-1:0] c);
        logic [CW-1:0] a;
        a = (r >> 1) * CW'(MAP_W / 2) + (c >> 1);
        return a[OADDR_W-1:0];
    endfunction

    assign pool_in1 = slot_r[0];
    assign pool_in2 = slot_r[1];
    assign pool_in3 = slot_r[2];
    assign pool_in4 = slot_r[3];
    assign wr_data  = result_r;

    // Next-state and window-position update.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        row_s   = row_r;
        col_s   = col_r;
        last_s  = (row_r + CW'(2) == CW'(MAP_H)) && (col_r + CW'(2) == CW'(MAP_W));
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = FETCH;
                    k_s     = 2'd0;
                    row_s   = CW'(0);
                    col_s   = CW'(0);
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (k_r == 2'd3) begin
                    state_s = CAP;
                    k_s     = 2'd0;
                end else begin
                    k_s = k_r + 2'd1;
                end
            end
            CAP:  state_s = POOL;
            POOL: state_s = WAIT;
            WAIT: begin
                if (pool_done) begin
                    state_s = WRITE;
                end else begin
                    state_s = WAIT;
                end
            end
            WRITE: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = FETCH;
                    k_s     = 2'd0;
                    if (col_r + CW'(2) == CW'(MAP_W)) begin
                        col_s = CW'(0);
                        row_s = row_r + CW'(2);
                    end else begin
                        col_s = col_r + CW'(2);
                    end
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, counters and control outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            k_r         <= 2'd0;
            row_r       <= CW'(0);
            col_r       <= CW'(0);
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            pool_enable <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
        end else begin
            state_r     <= state_s;
            k_r         <= k_s;
            row_r       <= row_s;
            col_r       <= col_s;
            busy        <= (state_s == FETCH) || (state_s == CAP) || (state_s == POOL) ||
                           (state_s == WAIT)  || (state_s == WRITE);
            done        <= (state_s == DONE);
            rd_en       <= (state_s == FETCH);
            rd_addr     <= rd_index(row_s, col_s, k_s);
            pool_enable <= (state_s == POOL) || (state_s == WAIT);
            wr_en       <= (state_s == WRITE);
            wr_addr     <= wr_index(row_s, col_s);
        end
    end

    // Window slots take read data one cycle after each issue; result held for WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                slot_r[i] <= '0;
            end
            result_r <= '0;
        end else begin
            if (state_r == FETCH && k_r != 2'd0) begin
                slot_r[k_r - 2'd1] <= rd_data;
            end else if (state_r == CAP) begin
                slot_r[3] <= rd_data;
            end
            if (state_r == WAIT && pool_done) begin
                result_r <= pool_result;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_controller.sv
// Directed bench for maxpool_controller: memory and pooling-unit models,
// per-scenario tasks with hand-computed expected writes and timing.
module tb_maxpool_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, rd_en, pool_enable, pool_done, wr_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data = 16'h0000;
    logic [15:0] pool_in1, pool_in2, pool_in3, pool_in4, wr_data;
    logic signed [15:0] pool_result;
    logic [1:0]  wr_addr;

    maxpool_controller #(.data_size(16), .MAP_W(4), .MAP_H(4), .ADDR_W(4), .OADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pool_in1(pool_in1), .pool_in2(pool_in2), .pool_in3(pool_in3), .pool_in4(pool_in4),
        .pool_enable(pool_enable), .pool_result(pool_result), .pool_done(pool_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // Feature-map memory with one-cycle read latency
    logic [15:0] mem [16];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Behavioural pooling unit: done after 1 enabled cycle (4 on window 1 in delay mode)
    logic [3:0] pcnt = 4'd0;
    int         nwr = 0;
    bit         delay_mode = 1'b0;
    always @(posedge clk) pcnt <= pool_enable ? pcnt + 4'd1 : 4'd0;
    always @(posedge clk) begin
        if (start && !busy) nwr <= 0;
        else if (wr_en)     nwr <= nwr + 1;
    end
    assign pool_done = pool_enable && (pcnt == ((delay_mode && nwr == 1) ? 4'd4 : 4'd1));
    always_comb begin
        logic signed [15:0] m;
        m = $signed(pool_in1);
        if ($signed(pool_in2) > m) m = $signed(pool_in2);
        if ($signed(pool_in3) > m) m = $signed(pool_in3);
        if ($signed(pool_in4) > m) m = $signed(pool_in4);
        pool_result = m;
    end

    int checks = 0;
    int fails  = 0;

    // Per-pass observations
    int          nw, rd_n, pe_n, done_n, done_cyc, busy_err, late_wr;
    bit          rst_zero;
    logic [1:0]  wa [8];
    logic [15:0] wd [8];
    int          wc [8];
    logic [3:0]  ra [32];
    logic [15:0] p0 [4];
    int          exp_rd [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

    function automatic bit outs_zero();
        return ({busy, done, rd_en, rd_addr, pool_enable, wr_en, wr_addr, wr_data,
                 pool_in1, pool_in2, pool_in3, pool_in4} == '0);
    endfunction

    task automatic run_pass(input int s1, input int s2, input int rst_cyc);
        nw = 0; rd_n = 0; pe_n = 0; done_n = 0; done_cyc = -1; busy_err = 0;
        late_wr = 0; rst_zero = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            start = (n == s1) || (n == s2);
            if (n == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                rst_zero = outs_zero();
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    if (wr_en) late_wr++;
                end
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            if (rd_en && rd_n < 32) begin ra[rd_n] = rd_addr; rd_n++; end
            if (pool_enable) begin
                if (pe_n == 0) begin p0[0] = pool_in1; p0[1] = pool_in2; p0[2] = pool_in3; p0[3] = pool_in4; end
                pe_n++;
            end
            if (wr_en) begin
                if (nw < 8) begin wa[nw] = wr_addr; wd[nw] = wr_data; wc[nw] = n; end
                nw++;
            end
            if (done) begin
                if (busy) busy_err++;
                if (done_n == 0) done_cyc = n;
                done_n++;
            end else if (done_n == 0) begin
                if (!busy) busy_err++;
            end else begin
                if (busy || rd_en) busy_err++;
            end
            if (done_n > 0 && n >= done_cyc + 4) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (!outs_zero()) begin
            fails++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input string tag);
        logic [1:0]  ea [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [15:0] ed [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
        for (int i = 0; i < 16; i++) mem[i] = 16'(i);
        run_pass(0, 0, 0);
        checks++;
        if (nw !== 4) begin fails++; $display("FAIL %s write_count: got %0d, required 4", tag, nw); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({wa[i], wd[i]} !== {ea[i], ed[i]} || wc[i] !== 8 * (i + 1)) begin
                fails++;
                $display("FAIL %s write%0d: got addr %0d data %h cycle %0d, required addr %0d data %h cycle %0d",
                         tag, i, wa[i], wd[i], wc[i], ea[i], ed[i], 8 * (i + 1));
            end
        end
        checks++;
        if (done_cyc !== 33 || done_n !== 1) begin
            fails++; $display("FAIL %s done: got cycle %0d count %0d, required cycle 33 count 1", tag, done_cyc, done_n);
        end
        checks++;
        if (busy_err !== 0) begin fails++; $display("FAIL %s busy: got %0d bad cycles, required 0", tag, busy_err); end
        checks++;
        if (rd_n !== 16) begin fails++; $display("FAIL %s read_count: got %0d, required 16", tag, rd_n); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ra[i] !== 4'(exp_rd[i])) begin
                fails++; $display("FAIL %s rd_addr%0d: got %0d, required %0d", tag, i, ra[i], exp_rd[i]);
            end
        end
        checks++;
        if ({p0[0], p0[1], p0[2], p0[3]} !== {16'd0, 16'd1, 16'd4, 16'd5}) begin
            fails++; $display("FAIL %s pool_in_w0: got %0d %0d %0d %0d, required 0 1 4 5", tag, p0[0], p0[1], p0[2], p0[3]);
        end
    endtask

    task automatic test_wait_stretch();
        int          ec [4] = '{8, 19, 27, 35};
        logic [15:0] ed [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
        for (int i = 0; i < 16; i++) mem[i] = 16'(i);
        delay_mode = 1'b1;
        run_pass(0, 0, 0);
        delay_mode = 1'b0;
        checks++;
        if (nw !== 4) begin fails++; $display("FAIL stretch write_count: got %0d, required 4", nw); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wd[i] !== ed[i] || wc[i] !== ec[i] || wa[i] !== 2'(i)) begin
                fails++; $display("FAIL stretch write%0d: got addr %0d data %h cycle %0d, required addr %0d data %h cycle %0d",
                                  i, wa[i], wd[i], wc[i], i, ed[i], ec[i]);
            end
        end
        checks++;
        if (pe_n !== 11 || done_cyc !== 36) begin
            fails++; $display("FAIL stretch timing: got enable cycles %0d done %0d, required 11 and 36", pe_n, done_cyc);
        end
    endtask

    task automatic test_signed();
        for (int i = 0; i < 16; i++) mem[i] = 16'h8000;
        run_pass(0, 0, 0);
        checks++;
        if (nw !== 4) begin fails++; $display("FAIL min_word write_count: got %0d, required 4", nw); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wd[i] !== 16'h8000) begin fails++; $display("FAIL min_word write%0d: got %h, required 8000", i, wd[i]); end
        end
        for (int i = 0; i < 16; i++) mem[i] = 16'(i);
        mem[0] = 16'hFFFD; mem[1] = 16'hFFFF; mem[4] = 16'hFFF9; mem[5] = 16'hFFFE;
        run_pass(0, 0, 0);
        checks++;
        if (wd[0] !== 16'hFFFF || wd[1] !== 16'd7) begin
            fails++; $display("FAIL negative_window: got %h %h, required ffff 0007", wd[0], wd[1]);
        end
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 16; i++) mem[i] = 16'(i);
        run_pass(5, 33, 0);
        checks++;
        if (nw !== 4 || done_n !== 1 || done_cyc !== 33 || rd_n !== 16 || busy_err !== 0) begin
            fails++; $display("FAIL start_ignored: got writes %0d dones %0d done_cyc %0d reads %0d busy_err %0d, required 4 1 33 16 0",
                              nw, done_n, done_cyc, rd_n, busy_err);
        end
        checks++;
        if (wc[3] !== 32 || wd[3] !== 16'd15) begin
            fails++; $display("FAIL start_ignored_last: got cycle %0d data %h, required 32 000f", wc[3], wd[3]);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) mem[i] = 16'(i);
        run_pass(0, 0, 12);
        checks++;
        if (rst_zero !== 1'b1) begin fails++; $display("FAIL midreset_outputs: got nonzero, required all 0"); end
        checks++;
        if (nw !== 1 || late_wr !== 0) begin
            fails++; $display("FAIL midreset_writes: got %0d before and %0d during reset, required 1 and 0", nw, late_wr);
        end
        @(negedge clk);
        test_basic("restart");
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_wait_stretch();
        test_signed();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/maxpool_controller.md
MAXPOOL_CONTROLLER -- requirements
Module: maxpool_controller

Interface
REQ-001 Parameter: data_size, 16, width of every feature-map and result word.
REQ-002 Parameter: MAP_W, 4, input feature-map width in words; even, >=2.
REQ-003 Parameter: MAP_H, 4, input feature-map height in rows; even, >=2.
REQ-004 Parameter: ADDR_W, 4, input read-address width; 2**ADDR_W >= MAP_W*MAP_H.
REQ-005 Parameter: OADDR_W, 2, output write-address width; 2**OADDR_W >= (MAP_W/2)*(MAP_H/2).
REQ-006 Ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-007 Ports: start in 1 begin a pooling pass; busy out 1 pass in progress; done out 1 one-cycle end-of-pass pulse.
REQ-008 Ports: rd_en out 1, rd_addr out ADDR_W: feature-map read request; rd_data in data_size, valid exactly one cycle after rd_en.
REQ-009 Ports: pool_in1..pool_in4 out data_size each: 2x2 window to pooling unit (top-left, top-right, bottom-left, bottom-right); pool_enable out 1.
REQ-010 Ports: pool_result in data_size, signed; pool_done in 1: pooling unit result and completion flag.
REQ-011 Ports: wr_en out 1, wr_addr out OADDR_W, wr_data out data_size: pooled-map write port.

Function
REQ-012 States SHALL be IDLE, FETCH, CAP, POOL, WAIT, WRITE, DONE.
REQ-013 IDLE: start=1 at clk edge SHALL clear row, col, k to 0 and enter FETCH; start in any other state SHALL be ignored.
REQ-014 FETCH: rd_en=1 for 4 consecutive cycles, k=0..3, rd_addr = row*MAP_W+col, +1, (row+1)*MAP_W+col, +1, in that order; after k=3 enter CAP.
REQ-015 rd_data SHALL be captured into window slot k-1 during the cycle after issue k-1 (slots 0-2 in FETCH, slot 3 in CAP); CAP -> POOL.
REQ-016 POOL: pool_in1..4 driven from registered slots, pool_enable=1; -> WAIT.
REQ-017 WAIT: pool_enable held 1 and pool_in1..4 held; pool_done=1 SHALL capture pool_result and enter WRITE; pool_done=0 SHALL remain WAIT indefinitely.
REQ-018 WRITE: wr_en=1 one cycle, wr_data = captured result, wr_addr = (row/2)*(MAP_W/2)+col/2; pool_enable=0.
REQ-019 After WRITE: col+=2; col wraps to 0 with row+=2 when col+2 == MAP_W; if last window (row+2==MAP_H and col+2==MAP_W) -> DONE, else -> FETCH.
REQ-020 DONE: done=1 for one cycle, busy=0; -> IDLE unconditionally; start sampled in DONE ignored.
REQ-021 busy=1 in FETCH, CAP, POOL, WAIT, WRITE; 0 in IDLE and DONE.
REQ-022 Latency with single-cycle pool_done: 8 cycles per window; first wr_en in 8th cycle after start-accept edge; done in cycle 8*(MAP_W/2)*(MAP_H/2)+1.
REQ-023 rd_en, pool_enable, wr_en SHALL be 0 in all states not listed as driving them; rd_addr/wr_addr values outside enable cycles are don't-care.
REQ-024 Controller SHALL not modify data: wr_data equals pool_result bit-exactly, including 0x8000.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, row=col=k=0, slots and captured result to 0, and busy, done, rd_en, pool_enable, wr_en, all data/address outputs to 0.
REQ-026 rst_n asserted mid-pass SHALL abandon the pass with no further wr_en; after release a new start SHALL begin from window (0,0).

Verification
REQ-027 4x4 map, word i = i, behavioural pool unit (done one cycle after enable): start -> wr (addr,data) = (0,5),(1,7),(2,13),(3,15) in cycles 8,16,24,32; done in cycle 33.
REQ-028 Same run: rd_addr sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15; pool_in1..4 for window 0 = 0,1,4,5.
REQ-029 Pool model delays pool_done 3 extra cycles on window 1: controller stays WAIT, pool_enable held, all later writes shifted by 3 cycles, data unchanged.
REQ-030 All words 0x8000 (signed minimum): four writes of 0x8000; words -3,-1,-7,-2 in window 0: wr_data 0xFFFF.
REQ-031 start pulsed in cycle 5 of pass and in DONE cycle: no restart, exactly 4 writes, single done.
REQ-032 rst_n low in cycle 12 (window 1 FETCH): all outputs 0 at once, no wr_en; restart after release reproduces REQ-027 exactly.
